// File: rtl/bus_pkg.sv
// Bus-side constants shared by the receive path and the top-level flow control.
package bus_pkg;

  localparam int BYTE_W             = 8;
  localparam int RX_FIFO_DEPTH_LOG2 = 9;
  localparam int RX_FIFO_AF_MARGIN  = 16;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// Read is read-first; callers handle same-address write/read themselves.
module sdp_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO between par16_receiver and cmd_parser.
// A RAM of 2**DEPTH_LOG2-1 entries feeds a single output register.
module rx_byte_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
  parameter int AF_MARGIN  = RX_FIFO_AF_MARGIN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int CAP_INT   = 1 << DEPTH_LOG2;
  localparam int RAM_DEPTH = CAP_INT - 1;
  localparam int RAM_LAST  = RAM_DEPTH - 1;

  localparam logic [DEPTH_LOG2:0]   CAP      = CAP_INT[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   AF_LIM   = AF_MARGIN[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = RAM_LAST[DEPTH_LOG2-1:0];
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // RAM depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [DEPTH_LOG2-1:0] ptrInc(input logic [DEPTH_LOG2-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_outValid;
  logic [BYTE_W-1:0]     r_outData;
  logic                  r_almostFull;
  logic                  r_overflow;
  logic                  r_fwdValid;
  logic [BYTE_W-1:0]     r_fwdData;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_ramCount;
  logic                  w_ramHasData;
  logic                  w_rdAdvance;
  logic                  w_bypass;
  logic                  w_ramWe;
  logic                  w_fwdNext;
  logic [DEPTH_LOG2:0]   w_levelNext;
  logic [DEPTH_LOG2-1:0] w_rdPtrNext;
  logic [BYTE_W-1:0]     w_ramQ;
  logic [BYTE_W-1:0]     w_headData;

  always_comb begin
    w_full       = (r_level == CAP);
    w_pop        = r_outValid & out_ready & ~flush;
    w_push       = in_valid & ~flush & (~w_full | w_pop);
    w_drop       = in_valid & ~flush & w_full & ~w_pop;
    w_ramCount   = r_level - {{DEPTH_LOG2{1'b0}}, r_outValid};
    w_ramHasData = (w_ramCount != '0);
    w_rdAdvance  = w_pop & w_ramHasData;
    w_bypass     = w_push & (~r_outValid | (w_pop & ~w_ramHasData));
    w_ramWe      = w_push & ~w_bypass;
    // A write landing on the slot being read this edge returns stale data, so forward it.
    w_fwdNext    = w_ramWe & (w_ramCount == {{DEPTH_LOG2{1'b0}}, w_rdAdvance});
    w_headData   = r_fwdValid ? r_fwdData : w_ramQ;

    w_levelNext = r_level;
    if (flush)                 w_levelNext = '0;
    else if (w_push && !w_pop) w_levelNext = r_level + LVL_ONE;
    else if (w_pop && !w_push) w_levelNext = r_level - LVL_ONE;

    w_rdPtrNext = r_rdPtr;
    if (reset || flush)   w_rdPtrNext = '0;
    else if (w_rdAdvance) w_rdPtrNext = ptrInc(r_rdPtr);
  end

  sdp_ram #(
    .WIDTH  (BYTE_W),
    .ADDR_W (DEPTH_LOG2),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_waddr (r_wrPtr),
    .i_wdata (in_data),
    .i_raddr (w_rdPtrNext),
    .o_rdata (w_ramQ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr      <= '0;
      r_wrPtr      <= '0;
      r_level      <= '0;
      r_outValid   <= 1'b0;
      r_outData    <= '0;
      r_almostFull <= 1'b0;
      r_overflow   <= 1'b0;
      r_fwdValid   <= 1'b0;
      r_fwdData    <= '0;
    end else begin
      r_level      <= w_levelNext;
      r_almostFull <= (CAP - w_levelNext) <= AF_LIM;
      r_overflow   <= w_drop | (r_overflow & ~overflow_clr);
      r_rdPtr      <= w_rdPtrNext;
      r_fwdValid   <= w_fwdNext;
      if (w_fwdNext) r_fwdData <= in_data;

      if (flush) begin
        r_wrPtr    <= '0;
        r_outValid <= 1'b0;
      end else begin
        if (w_ramWe) r_wrPtr <= ptrInc(r_wrPtr);
        // Empty RAM feeds the output register directly; otherwise refill from the head.
        if (w_bypass) begin
          r_outData  <= in_data;
          r_outValid <= 1'b1;
        end else if (w_rdAdvance) begin
          r_outData  <= w_headData;
        end else if (w_pop) begin
          r_outValid <= 1'b0;
        end
      end
    end
  end

  assign out_data    = r_outData;
  assign out_valid   = r_outValid;
  assign level       = r_level;
  assign almost_full = r_almostFull;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo at capacity 16, almost-full margin 2.
module tb_rx_byte_fifo;

  localparam int DL2 = 4;
  localparam int AFM = 2;
  localparam int CAP = 1 << DL2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic [7:0]     in_data = '0;
  logic           in_valid = 1'b0;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DL2:0]   level;
  logic           almost_full;
  logic           overflow;
  logic           overflow_clr = 1'b0;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] expQ[$];
  logic [7:0] lastGot = '0;
  int         mLevel = 0;
  bit         mOverflow = 1'b0;
  bit         mPop, mPush, mDrop;

  rx_byte_fifo #(.DEPTH_LOG2(DL2), .AF_MARGIN(AFM)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Every accepted byte the consumer takes is checked against the queue of expected bytes.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      tests++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL scoreboard_extra got=%02h expected=none", out_data);
      end else begin
        logic [7:0] exp;
        exp = expQ.pop_front();
        if (out_data !== exp) begin
          fails++;
          $display("[TB] FAIL scoreboard_data got=%02h expected=%02h", out_data, exp);
        end
      end
      lastGot = out_data;
    end
  end

  task automatic drive(input bit rst, input bit iv, input logic [7:0] d,
                       input bit rdy, input bit fl, input bit clr);
    reset = rst; in_valid = iv; in_data = d; out_ready = rdy; flush = fl; overflow_clr = clr;
    if (rst) begin
      mLevel = 0; mOverflow = 1'b0; expQ.delete();
    end else begin
      mPop  = (mLevel > 0) && rdy && !fl;
      mDrop = iv && !fl && (mLevel == CAP) && !mPop;
      mPush = iv && !fl && ((mLevel < CAP) || mPop);
      if (fl) begin
        mLevel = 0; expQ.delete();
      end else begin
        if (mPush) begin expQ.push_back(d); mLevel++; end
        if (mPop) mLevel--;
      end
      mOverflow = mDrop || (mOverflow && !clr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) drive(1, 0, 8'h00, 0, 0, 0);
    tests += 5;
    if (out_valid !== 1'b0)   begin fails++; $display("[TB] FAIL reset_valid got=%b expected=0", out_valid); end
    if (out_data !== 8'h00)   begin fails++; $display("[TB] FAIL reset_data got=%02h expected=00", out_data); end
    if (level !== '0)         begin fails++; $display("[TB] FAIL reset_level got=%0d expected=0", level); end
    if (almost_full !== 1'b0) begin fails++; $display("[TB] FAIL reset_af got=%b expected=0", almost_full); end
    if (overflow !== 1'b0)    begin fails++; $display("[TB] FAIL reset_ovf got=%b expected=0", overflow); end
    repeat (6) drive(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_single_push();
    drive(0, 1, 8'hA5, 0, 0, 0);
    tests += 3;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid got=%b expected=1", out_valid); end
    if (out_data !== 8'hA5) begin fails++; $display("[TB] FAIL single_data got=%02h expected=a5", out_data); end
    if (level !== 5'd1)     begin fails++; $display("[TB] FAIL single_level got=%0d expected=1", level); end
    drive(0, 0, 8'h00, 0, 0, 0);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_hold got=%b expected=1", out_valid); end
    drive(0, 0, 8'h00, 1, 0, 0);
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_pop_valid got=%b expected=0", out_valid); end
    if (level !== '0)       begin fails++; $display("[TB] FAIL single_pop_level got=%0d expected=0", level); end
    if (expQ.size() != 0)   begin fails++; $display("[TB] FAIL single_drained got=%0d expected=0", expQ.size()); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 8'(i), 1, 0, 0);
      tests += 2;
      if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL stream_valid byte=%0d got=%b expected=1", i, out_valid); end
      if (level > 5'd2 || level !== 5'(mLevel)) begin
        fails++; $display("[TB] FAIL stream_level byte=%0d got=%0d expected=%0d", i, level, mLevel);
      end
    end
    drive(0, 0, 8'h00, 1, 0, 0);
    tests += 2;
    if (expQ.size() != 0)   begin fails++; $display("[TB] FAIL stream_drained got=%0d expected=0", expQ.size()); end
    if (lastGot !== 8'hFF)  begin fails++; $display("[TB] FAIL stream_last got=%02h expected=ff", lastGot); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) begin
      drive(0, 1, 8'(i), 0, 0, 0);
      tests += 2;
      if (almost_full !== (i >= 14)) begin fails++; $display("[TB] FAIL ovf_af push=%0d got=%b expected=%b", i, almost_full, (i >= 14)); end
      if (level !== 5'(mLevel))      begin fails++; $display("[TB] FAIL ovf_level push=%0d got=%0d expected=%0d", i, level, mLevel); end
    end
    tests += 2;
    if (level !== 5'd16)   begin fails++; $display("[TB] FAIL ovf_full_level got=%0d expected=16", level); end
    if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag got=%b expected=1", overflow); end
    repeat (16) drive(0, 0, 8'h00, 1, 0, 0);
    tests += 3;
    if (level !== '0)      begin fails++; $display("[TB] FAIL ovf_drain_level got=%0d expected=0", level); end
    if (expQ.size() != 0)  begin fails++; $display("[TB] FAIL ovf_drained got=%0d expected=0", expQ.size()); end
    if (lastGot !== 8'd16) begin fails++; $display("[TB] FAIL ovf_last got=%02h expected=10", lastGot); end
  endtask

  task automatic test_overflow_clr();
    for (int i = 0; i < CAP; i++) drive(0, 1, 8'(8'h40 + i), 0, 0, 0);
    drive(0, 1, 8'hEE, 0, 0, 1);
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL clr_set_wins got=%b expected=1", overflow); end
    drive(0, 0, 8'h00, 0, 0, 1);
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL clr_alone got=%b expected=0", overflow); end
  endtask

  task automatic test_full_pop();
    drive(0, 1, 8'h5C, 1, 0, 0);
    tests += 2;
    if (level !== 5'd16)   begin fails++; $display("[TB] FAIL fullpop_level got=%0d expected=16", level); end
    if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL fullpop_ovf got=%b expected=0", overflow); end
    repeat (16) drive(0, 0, 8'h00, 1, 0, 0);
    tests += 2;
    if (lastGot !== 8'h5C) begin fails++; $display("[TB] FAIL fullpop_last got=%02h expected=5c", lastGot); end
    if (expQ.size() != 0)  begin fails++; $display("[TB] FAIL fullpop_drained got=%0d expected=0", expQ.size()); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) drive(0, 1, 8'(8'h80 + i), 0, 0, 0);
    tests++;
    if (level !== 5'd10) begin fails++; $display("[TB] FAIL flush_pre_level got=%0d expected=10", level); end
    drive(0, 1, 8'h77, 1, 1, 0);
    tests += 3;
    if (level !== '0)               begin fails++; $display("[TB] FAIL flush_level got=%0d expected=0", level); end
    if (out_valid !== 1'b0)         begin fails++; $display("[TB] FAIL flush_valid got=%b expected=0", out_valid); end
    if (overflow !== mOverflow)     begin fails++; $display("[TB] FAIL flush_ovf got=%b expected=%b", overflow, mOverflow); end
    drive(0, 1, 8'h33, 0, 0, 0);
    tests += 2;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL flush_refill_valid got=%b expected=1", out_valid); end
    if (out_data !== 8'h33) begin fails++; $display("[TB] FAIL flush_refill_data got=%02h expected=33", out_data); end
    drive(0, 0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i <= CAP; i++) drive(0, 1, 8'(8'hC0 + i), 0, 0, 0);
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL midrst_pre_ovf got=%b expected=1", overflow); end
    drive(1, 1, 8'h99, 1, 0, 0);
    tests += 4;
    if (level !== '0)         begin fails++; $display("[TB] FAIL midrst_level got=%0d expected=0", level); end
    if (out_valid !== 1'b0)   begin fails++; $display("[TB] FAIL midrst_valid got=%b expected=0", out_valid); end
    if (overflow !== 1'b0)    begin fails++; $display("[TB] FAIL midrst_ovf got=%b expected=0", overflow); end
    if (almost_full !== 1'b0) begin fails++; $display("[TB] FAIL midrst_af got=%b expected=0", almost_full); end
    drive(0, 1, 8'h12, 0, 0, 0);
    tests++;
    if (out_data !== 8'h12) begin fails++; $display("[TB] FAIL midrst_head got=%02h expected=12", out_data); end
    drive(0, 0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit iv, rdy, fl, clr;
      iv  = ($urandom_range(0, 3) != 0);
      rdy = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 79) == 0);
      clr = ($urandom_range(0, 15) == 0);
      drive(0, iv, 8'($urandom), rdy, fl, clr);
      tests += 4;
      if (level !== 5'(mLevel)) begin fails++; $display("[TB] FAIL rand_level cyc=%0d got=%0d expected=%0d", c, level, mLevel); end
      if (out_valid !== (mLevel > 0)) begin fails++; $display("[TB] FAIL rand_valid cyc=%0d got=%b expected=%b", c, out_valid, (mLevel > 0)); end
      if (overflow !== mOverflow) begin fails++; $display("[TB] FAIL rand_ovf cyc=%0d got=%b expected=%b", c, overflow, mOverflow); end
      if (almost_full !== ((CAP - mLevel) <= AFM)) begin
        fails++; $display("[TB] FAIL rand_af cyc=%0d got=%b expected=%b", c, almost_full, ((CAP - mLevel) <= AFM));
      end
    end
    repeat (CAP + 2) drive(0, 0, 8'h00, 1, 0, 0);
    tests++;
    if (expQ.size() != 0) begin fails++; $display("[TB] FAIL rand_drained got=%0d expected=0", expQ.size()); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_stream();
    test_overflow();
    test_overflow_clr();
    test_full_pop();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
- Byte FIFO inserted between par16_receiver (rxd_data / rxd_data_ready) and cmd_parser.
- Absorbs bursts from the RPi parallel bus while cmd_parser stalls, e.g. while string_process_match is busy.
- Presents a first-word-fall-through (FWFT) valid/ready stream to cmd_parser.
- Provides an almost_full flag for bus flow control, a sticky overflow flag, and a flush on desync.

Parameters:
- DEPTH_LOG2, 9, log2 of storage depth; capacity is 2**DEPTH_LOG2 bytes, output register included.
- AF_MARGIN, 16, almost_full asserts when free space <= AF_MARGIN.

Ports:
- clk  in  1  system clock (100 MHz domain)
- reset  in  1  synchronous, active-high
- flush  in  1  connect to desync; synchronous clear of contents
- in_data  in  8  byte from par16_receiver
- in_valid  in  1  single-cycle strobe; no backpressure upstream
- out_data  out  8  head byte, valid while out_valid
- out_valid  out  1  head byte available
- out_ready  in  1  consumer accepts head this cycle
- level  out  DEPTH_LOG2+1  bytes held, output register included
- almost_full  out  1  registered watermark flag
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset values: out_valid=0, out_data=0, level=0, almost_full=0, overflow=0. Read/write pointers are 0. RAM contents are don't-care.
- Storage is a RAM of 2**DEPTH_LOG2 - 1 entries plus one output register, for a total capacity of 2**DEPTH_LOG2.
- Push happens when in_valid=1, flush=0 and (level < capacity, or a pop occurs in the same cycle).
- Pop happens when out_valid=1 and out_ready=1.
- level updates every cycle: +1 on push only, -1 on pop only, unchanged when both or neither occur. It never wraps.
- FWFT latency:
  - A byte pushed at edge E0 into an empty FIFO gives out_valid=1 with that byte after edge E1 (one cycle of latency).
  - This holds because the RAM is bypassed straight into the output register when the RAM is empty.
- Refill after a pop:
  - If the RAM holds data, the next byte is loaded into the output register on the same edge as the pop.
  - out_valid therefore stays 1 across back-to-back pops. Sustained throughput is 1 byte/clk.
- Ordering is strict FIFO. A byte pushed while a pop occurs goes behind all bytes already held.
- Full + push without pop:
  - The byte is dropped and overflow is set on the next edge.
  - level, the pointers and the contents are unchanged.
- Full + push with pop: the push is accepted and level stays at capacity.
- overflow_clr and an overflow event in the same cycle: set wins, so overflow stays 1.
- almost_full is registered from the next level; it is 1 when (capacity - level_next) <= AF_MARGIN.
- Flush:
  - On the next edge, pointers, level and out_valid go to 0.
  - overflow is not affected.
  - in_valid in the same cycle is discarded and does not count as an overflow.
  - A pop in the same cycle is ignored; the consumer must not rely on it.
- Reset mid-stream: identical to flush, and additionally clears overflow.
- Pointers are DEPTH_LOG2-bit and wrap modulo the RAM depth. Empty/full are derived from level, never from pointer equality.

Decomposition:
- Shared package bus_pkg:
  - RX_FIFO_DEPTH_LOG2
  - RX_FIFO_AF_MARGIN
  - byte width constant BYTE_W=8
  - These are also referenced by top-level flow control.
- One sub-module, sdp_ram:
  - Simple dual-port RAM with a synchronous write port and a synchronous read port.
  - Parameters: width and address bits. Inferred as block RAM.
- Everything else lives in rx_byte_fifo: bypass mux, output register, counters and flags.

Test Plan:
- Reset, then single push 0xA5 at cycle 10 with out_ready=0 -> out_valid=1 and out_data=0xA5 from cycle 11; level=1. Then out_ready=1 for 1 cycle -> out_valid=0, level=0.
- Push 0x00..0xFF continuously with out_ready=1 -> output sequence is identical and in order, out_valid is never deasserted after the first byte, and level stays <= 2.
- DEPTH_LOG2=4 (capacity 16), AF_MARGIN=2, out_ready=0, push 17 bytes -> almost_full rises after the 14th push, level=16, and the 17th byte is dropped with overflow=1. Draining then yields bytes 1..16 only.
- Full FIFO, push 0x5C together with a pop -> level stays 16, overflow stays 0, and 0x5C is the last byte drained.
- 10 bytes queued, then flush with a simultaneous in_valid -> next cycle level=0, out_valid=0, overflow unchanged. A subsequent push of 0x33 appears as the head after 1 cycle.
- overflow=1, then overflow_clr together with another full-drop event -> overflow stays 1. overflow_clr alone on a later cycle -> overflow=0.
